// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing the register file's single read port between two requesters.
// Optional grant counters are built when RD_ARB_PERF_EN is defined.
module regfile_read_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [ADDR_W-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rd_sel,
  output logic              rd_valid0,
  output logic              rd_valid1,
  output logic [DATA_W-1:0] rd_data,
  output logic [15:0]       perf_cnt0,
  output logic [15:0]       perf_cnt1
);

  typedef enum logic {IDLE, READ} state_t;

  state_t            state_reg, state_next;
  logic              last_reg;
  logic              sel_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              gnt0_reg, gnt1_reg;
  logic              rd_valid0_reg, rd_valid1_reg;
  logic [DATA_W-1:0] rd_data_reg;
  logic              any_req;
  logic              win_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // On a tie the port that did not win last time is served.
  always_comb begin
    any_req    = req0 | req1;
    win_next   = (req0 && req1) ? ~last_reg : req1;
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = any_req ? READ : IDLE;
      READ:    state_next = any_req ? READ : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_reg      <= 1'b1;
      sel_reg       <= 1'b0;
      addr_reg      <= '0;
      gnt0_reg      <= 1'b0;
      gnt1_reg      <= 1'b0;
      rd_valid0_reg <= 1'b0;
      rd_valid1_reg <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      if (any_req) begin
        last_reg <= win_next;
        sel_reg  <= win_next;
        addr_reg <= win_next ? addr1 : addr0;
        gnt0_reg <= ~win_next;
        gnt1_reg <= win_next;
      end else begin
        gnt0_reg <= 1'b0;
        gnt1_reg <= 1'b0;
      end
      // The word for the grant issued last cycle is captured as READ ends.
      if (state_reg == READ) begin
        rd_data_reg   <= rf_rdata;
        rd_valid0_reg <= ~sel_reg;
        rd_valid1_reg <= sel_reg;
      end else begin
        rd_valid0_reg <= 1'b0;
        rd_valid1_reg <= 1'b0;
      end
    end
  end

  assign gnt0      = gnt0_reg;
  assign gnt1      = gnt1_reg;
  assign rf_raddr  = addr_reg;
  assign rd_sel    = sel_reg;
  assign rd_valid0 = rd_valid0_reg;
  assign rd_valid1 = rd_valid1_reg;
  assign rd_data   = rd_data_reg;

`ifdef RD_ARB_PERF_EN
  logic [15:0] perf_cnt0_reg, perf_cnt1_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt0_reg <= '0;
      perf_cnt1_reg <= '0;
    end else begin
      if (gnt0_reg && perf_cnt0_reg != 16'hFFFF) perf_cnt0_reg <= perf_cnt0_reg + 16'd1;
      if (gnt1_reg && perf_cnt1_reg != 16'hFFFF) perf_cnt1_reg <= perf_cnt1_reg + 16'd1;
    end
  end

  assign perf_cnt0 = perf_cnt0_reg;
  assign perf_cnt1 = perf_cnt1_reg;
`else
  assign perf_cnt0 = 16'h0000;
  assign perf_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_regfile_read_arbiter.sv
// Bench for regfile_read_arbiter: directed scenarios plus random requesters checked
// against a transaction-level model of the arbitration and data return rules.
module tb_regfile_read_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1;
  logic [4:0]  addr0, addr1;
  logic        gnt0, gnt1;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        rd_sel, rd_valid0, rd_valid1;
  logic [31:0] rd_data;
  logic [15:0] perf_cnt0, perf_cnt1;

  logic [31:0] rf [32];
  assign rf_rdata = rf[rf_raddr];

  always #5 clk = ~clk;

  regfile_read_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
    .gnt0(gnt0), .gnt1(gnt1), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rd_sel(rd_sel), .rd_valid0(rd_valid0), .rd_valid1(rd_valid1), .rd_data(rd_data),
    .perf_cnt0(perf_cnt0), .perf_cnt1(perf_cnt1)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: who won last, the read in flight, and the outputs expected after each edge.
  logic        m_last;
  logic        m_inflight;
  logic        m_port;
  logic [4:0]  m_addr;
  logic        e_gnt0, e_gnt1, e_sel, e_v0, e_v1;
  logic [4:0]  e_raddr;
  logic [31:0] e_data;
  int          m_cnt0, m_cnt1;
  logic [15:0] e_perf0, e_perf1;

  task automatic reset_model();
    m_last = 1'b1; m_inflight = 1'b0; m_port = 1'b0; m_addr = '0;
    e_gnt0 = 0; e_gnt1 = 0; e_sel = 0; e_v0 = 0; e_v1 = 0; e_raddr = '0; e_data = '0;
    m_cnt0 = 0; m_cnt1 = 0; e_perf0 = '0; e_perf1 = '0;
  endtask

  // Drive one cycle of requests, advance one edge and update the model.
  task automatic cycle(input logic r0, input logic [4:0] a0, input logic r1, input logic [4:0] a1);
    logic w;
    req0 = r0; addr0 = a0; req1 = r1; addr1 = a1;
    @(posedge clk);
    if (e_gnt0 && m_cnt0 < 65535) m_cnt0++;
    if (e_gnt1 && m_cnt1 < 65535) m_cnt1++;
    if (m_inflight) begin
      e_v0 = !m_port; e_v1 = m_port; e_data = rf[m_addr];
    end else begin
      e_v0 = 0; e_v1 = 0;
    end
    if (r0 || r1) begin
      w = (r0 && r1) ? !m_last : r1;
      m_last = w; e_gnt0 = !w; e_gnt1 = w; e_sel = w;
      e_raddr = w ? a1 : a0;
      m_inflight = 1; m_port = w; m_addr = e_raddr;
    end else begin
      e_gnt0 = 0; e_gnt1 = 0; m_inflight = 0;
    end
`ifdef RD_ARB_PERF_EN
    e_perf0 = 16'(m_cnt0); e_perf1 = 16'(m_cnt1);
`else
    e_perf0 = 16'h0000; e_perf1 = 16'h0000;
`endif
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    reset_model();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req0 = 0; req1 = 0; addr0 = '0; addr1 = '0;
    reset_model();
    @(negedge clk); @(negedge clk);
    n_cmp++;
    if ({gnt0, gnt1, rd_valid0, rd_valid1, rd_sel, rf_raddr, rd_data, perf_cnt0, perf_cnt1} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got gnt=%b%b v=%b%b sel=%b raddr=%0d data=%h perf=%h/%h, want all 0",
               gnt0, gnt1, rd_valid0, rd_valid1, rd_sel, rf_raddr, rd_data, perf_cnt0, perf_cnt1);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 5'd0, 0, 5'd0);
      n_cmp++;
      if ({gnt0, gnt1, rd_valid0, rd_valid1} !== {e_gnt0, e_gnt1, e_v0, e_v1}) begin
        n_err++;
        $display("FAIL idle_no_grant cyc %0d: got gnt=%b%b v=%b%b, want 0000", i, gnt0, gnt1, rd_valid0, rd_valid1);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_single_read();
    rf[3] = 32'hFFFF0000;
    cycle(1, 5'd3, 0, 5'd0);
    n_cmp++;
    if ({gnt0, gnt1, rf_raddr, rd_sel} !== {1'b1, 1'b0, 5'd3, 1'b0}) begin
      n_err++;
      $display("FAIL single_grant: got gnt=%b%b raddr=%0d sel=%b, want gnt=10 raddr=3 sel=0", gnt0, gnt1, rf_raddr, rd_sel);
    end
    cycle(0, 5'd0, 0, 5'd0);
    n_cmp++;
    if ({rd_valid0, rd_valid1, rd_data, gnt0} !== {1'b1, 1'b0, 32'hFFFF0000, 1'b0}) begin
      n_err++;
      $display("FAIL single_data: got v=%b%b data=%h gnt0=%b, want v=10 data=ffff0000 gnt0=0", rd_valid0, rd_valid1, rd_data, gnt0);
    end
    cycle(0, 5'd0, 0, 5'd0);
    n_cmp++;
    if ({rd_valid0, rd_data, rf_raddr} !== {1'b0, 32'hFFFF0000, 5'd3}) begin
      n_err++;
      $display("FAIL single_hold: got v0=%b data=%h raddr=%0d, want v0=0 data=ffff0000 raddr=3", rd_valid0, rd_data, rf_raddr);
    end
    $display("test_single_read done");
  endtask

  task automatic test_tie_alternate();
    apply_reset();
    rf[1] = 32'h1111_0001; rf[2] = 32'h2222_0002;
    for (int i = 0; i < 6; i++) begin
      cycle(1, 5'd1, 1, 5'd2);
      n_cmp++;
      if ({gnt0, gnt1} !== {i[0] == 1'b0, i[0] == 1'b1} || rf_raddr !== e_raddr) begin
        n_err++;
        $display("FAIL tie_order cyc %0d: got gnt=%b%b raddr=%0d, want gnt=%b%b raddr=%0d",
                 i, gnt0, gnt1, rf_raddr, i[0] == 1'b0, i[0] == 1'b1, e_raddr);
      end
      if (i > 0) begin
        n_cmp++;
        if ({rd_valid0, rd_valid1, rd_data} !== {e_v0, e_v1, e_data}) begin
          n_err++;
          $display("FAIL tie_data cyc %0d: got v=%b%b data=%h, want v=%b%b data=%h",
                   i, rd_valid0, rd_valid1, rd_data, e_v0, e_v1, e_data);
        end
      end
    end
    cycle(0, 5'd0, 0, 5'd0);
    $display("test_tie_alternate done");
  endtask

  task automatic test_hold_port1();
    rf[7] = 32'h0000FFFF;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) cycle(0, 5'd0, 1, 5'd7);
      else       cycle(0, 5'd0, 0, 5'd0);
      n_cmp++;
      if ({gnt0, gnt1} !== {1'b0, i < 4}) begin
        n_err++;
        $display("FAIL hold1_grant cyc %0d: got gnt=%b%b, want gnt=0%b", i, gnt0, gnt1, i < 4);
      end
      if (i > 0) begin
        n_cmp++;
        if ({rd_valid0, rd_valid1, rd_data} !== {1'b0, 1'b1, 32'h0000FFFF}) begin
          n_err++;
          $display("FAIL hold1_data cyc %0d: got v=%b%b data=%h, want v=01 data=0000ffff", i, rd_valid0, rd_valid1, rd_data);
        end
      end
    end
    cycle(0, 5'd0, 0, 5'd0);
    $display("test_hold_port1 done");
  endtask

  task automatic test_reset_mid_read();
    rf[4] = 32'h88888888; rf[5] = 32'h5555_0005;
    cycle(1, 5'd4, 0, 5'd0);
    req0 = 0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({gnt0, gnt1, rd_valid0, rd_valid1, rd_sel, rf_raddr, rd_data, perf_cnt0, perf_cnt1} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: got gnt=%b%b v=%b%b sel=%b raddr=%0d data=%h perf=%h/%h, want all 0",
               gnt0, gnt1, rd_valid0, rd_valid1, rd_sel, rf_raddr, rd_data, perf_cnt0, perf_cnt1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    reset_model();
    cycle(1, 5'd5, 1, 5'd6);
    n_cmp++;
    if ({rd_valid0, rd_valid1, gnt0, gnt1} !== {1'b0, 1'b0, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL midreset_after: got v=%b%b gnt=%b%b, want v=00 gnt=10", rd_valid0, rd_valid1, gnt0, gnt1);
    end
    cycle(0, 5'd0, 0, 5'd0);
    n_cmp++;
    if ({rd_valid0, rd_data} !== {1'b1, 32'h5555_0005}) begin
      n_err++;
      $display("FAIL midreset_first_data: got v0=%b data=%h, want v0=1 data=55550005", rd_valid0, rd_data);
    end
    $display("test_reset_mid_read done");
  endtask

  task automatic test_perf();
    apply_reset();
    cycle(1, 5'd1, 1, 5'd2);
    cycle(1, 5'd1, 1, 5'd2);
    cycle(1, 5'd1, 1, 5'd2);
    cycle(1, 5'd1, 1, 5'd2);
    cycle(1, 5'd3, 0, 5'd0);
    cycle(0, 5'd0, 0, 5'd0);
    cycle(0, 5'd0, 0, 5'd0);
    n_cmp++;
`ifdef RD_ARB_PERF_EN
    if (perf_cnt0 !== 16'd3 || perf_cnt1 !== 16'd2) begin
      n_err++;
      $display("FAIL perf_counts: got %0d/%0d, want 3/2", perf_cnt0, perf_cnt1);
    end
`else
    if (perf_cnt0 !== 16'd0 || perf_cnt1 !== 16'd0) begin
      n_err++;
      $display("FAIL perf_counts: got %0d/%0d, want 0/0", perf_cnt0, perf_cnt1);
    end
`endif
    $display("test_perf done");
  endtask

  task automatic test_random();
    logic       r0 = 0, r1 = 0;
    logic [4:0] a0 = '0, a1 = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    for (int i = 0; i < 300; i++) begin
      // A requester holds until granted, then either goes quiet or issues a new request.
      if (!r0 || e_gnt0) begin r0 = 1'($urandom_range(0, 1)); a0 = 5'($urandom_range(0, 31)); end
      if (!r1 || e_gnt1) begin r1 = 1'($urandom_range(0, 1)); a1 = 5'($urandom_range(0, 31)); end
      cycle(r0, a0, r1, a1);
      n_cmp++;
      if ({gnt0, gnt1, rd_valid0, rd_valid1, rd_sel, rf_raddr, rd_data, perf_cnt0, perf_cnt1} !==
          {e_gnt0, e_gnt1, e_v0, e_v1, e_sel, e_raddr, e_data, e_perf0, e_perf1}) begin
        n_err++;
        $display("FAIL random cyc %0d: got gnt=%b%b v=%b%b sel=%b raddr=%0d data=%h perf=%0d/%0d, want gnt=%b%b v=%b%b sel=%b raddr=%0d data=%h perf=%0d/%0d",
                 i, gnt0, gnt1, rd_valid0, rd_valid1, rd_sel, rf_raddr, rd_data, perf_cnt0, perf_cnt1,
                 e_gnt0, e_gnt1, e_v0, e_v1, e_sel, e_raddr, e_data, e_perf0, e_perf1);
      end
      n_cmp++;
      if ((gnt0 && gnt1) || (rd_valid0 && rd_valid1)) begin
        n_err++;
        $display("FAIL exclusive cyc %0d: got gnt=%b%b v=%b%b, want at most one of each", i, gnt0, gnt1, rd_valid0, rd_valid1);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h0101_0101;
    test_reset();
    test_single_read();
    test_tie_alternate();
    test_hold_port1();
    test_reset_mid_read();
    test_perf();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_read_arbiter.md
# regfile_read_arbiter

Shares the register file's single read port between two requesters: port 0 is the multicycle control path's operand fetch, port 1 is the debug/trace read path. The block arbitrates round-robin and latches the winning address onto the register-file read address. It captures the returned word and hands it back to the winner with a tagged valid pulse. It also drives the select of the read-data steering mux (read_mux) so the datapath knows which requester owns the word in flight.

## Interface
Parameters:
- ADDR_W, 5, register index width
- DATA_W, 32, register word width

Ports:
- clk  in  1  single system clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset; all registers clear immediately on assertion
- req0  in  1  read request, port 0
- addr0  in  ADDR_W  register index, port 0; valid while req0 high
- req1  in  1  read request, port 1
- addr1  in  ADDR_W  register index, port 1; valid while req1 high
- gnt0  out  1  one-cycle grant pulse, port 0
- gnt1  out  1  one-cycle grant pulse, port 1
- rf_raddr  out  ADDR_W  register-file read address (registered)
- rf_rdata  in  DATA_W  register-file read data, combinational from rf_raddr
- rd_sel  out  1  read_mux select: 0 = word belongs to port 0, 1 = port 1
- rd_valid0  out  1  read data valid for port 0, one cycle
- rd_valid1  out  1  read data valid for port 1, one cycle
- rd_data  out  DATA_W  captured read word
- perf_cnt0  out  16  grant count, port 0 (see Configuration)
- perf_cnt1  out  16  grant count, port 1 (see Configuration)

## Operation
- FSM has two states:
  - IDLE: no read in flight.
  - READ: rf_raddr is driving a granted address.
- Transitions, evaluated each edge:
  - IDLE, any req → READ.
  - IDLE, no req → IDLE.
  - READ, any req → READ (new grant, back-to-back).
  - READ, no req → IDLE.
- Arbitration at the edge:
  - Only one req high: that port wins.
  - Both high: the port that did not win last (last_q) wins.
  - last_q updates on every grant; it resets to 1, so port 0 wins the first tie.
- On a grant:
  - addr_q ← winning address; rf_raddr = addr_q.
  - sel_q ← winner; rd_sel = sel_q.
  - gntX = 1 for exactly the following cycle.
- Data capture: at the edge ending a READ cycle, rd_data ← rf_rdata, and rd_validX pulses for one cycle, where X = the sel_q of that READ.
- Requester rules:
  - Hold req and addr until gnt is seen.
  - Drop req during the gnt cycle; req still high at the edge ending the gnt cycle is a new request.
  - A loser keeps req high and is served at the next edge; it never waits more than one extra cycle.
- Outputs hold their last value when nothing changes:
  - rd_data holds until the next capture.
  - rf_raddr and rd_sel hold in IDLE.
- Reset values: state IDLE; gnt0, gnt1, rd_valid0, rd_valid1 = 0; rf_raddr = 0; rd_sel = 0; rd_data = 0; last_q = 1; perf counters = 0.
- Reset mid-read: the in-flight read is discarded with no rd_valid pulse. Requesters must re-issue.

## Timing
- Latency: req sampled at edge k → gnt and rf_raddr valid in cycle k..k+1 → rd_valid and rd_data valid in cycle k+1..k+2.
- Throughput: one read per cycle under continuous requests.
- Simultaneous requests:
  - Back-to-back ties alternate 0,1,0,1.
  - A single continuous requester gets a grant every cycle.
- rf_rdata must settle within the READ cycle; it is sampled only at the edge ending READ.
- gnt0 and gnt1 are never high in the same cycle; the same holds for rd_valid0 and rd_valid1.

## Configuration
- Macro: RD_ARB_PERF_EN.
- Defined: perf_cnt0 and perf_cnt1 increment on each gnt0/gnt1 pulse and saturate at 16'hFFFF; cleared only by reset.
- Undefined: counters are not built; perf_cnt0 and perf_cnt1 are tied to 16'h0000. Arbitration is unchanged.

## Test plan
- Reset then idle → all outputs 0; after release with no req, state stays IDLE and no gnt appears for 10 cycles.
- req0=1, addr0=5'd3 for one cycle, RF r3=32'hFFFF0000 → gnt0 next cycle with rf_raddr=3 and rd_sel=0; following cycle rd_valid0=1, rd_data=32'hFFFF0000.
- req0 and req1 both high and held, addr0=1, addr1=2 → grants in order 0,1,0,1 on consecutive cycles; rd_data alternates r1, r2.
- req1 alone held 4 cycles, addr1=7, r7=32'h0000FFFF → gnt1 four consecutive cycles; four rd_valid1 pulses, each with 32'h0000FFFF.
- Assert rst_n low during a READ cycle (port 0, r4=32'h88888888) → no rd_valid0 pulse; all outputs 0 immediately; the first tie after release goes to port 0.
- With RD_ARB_PERF_EN: 3 grants to port 0 and 2 to port 1 → perf_cnt0=3, perf_cnt1=2. Without it, both read 0.
